mcp3202_chan_sched: RTL and testbench

//  Frame scheduler for the MCP3202 ADC path. Generates the per-frame sample tick.

---
 rtl/mcp3202_chan_sched.sv | 210 +++++++++++++++++++++
 tb/tb_mcp3202_chan_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3202_chan_sched.sv
// ---------------------------------------------------------------------------
// mcp3202_chan_sched
//   Frame scheduler for the MCP3202 ADC path. A free-running divider produces
//   one frame tick every FCLK/FSMPL clocks. On each tick the enabled channels
//   are marked pending. The single start-triggered SPI master is then
//   time-shared: one conversion per pending channel, CH0 first. Each result is
//   demultiplexed into its own per-channel register with a one-cycle strobe.
//
//   Optional build macro: MCP3202_SCHED_TIMEOUT_EN
//     defined   -> WAIT watchdog aborts a conversion after TIMEOUT_CYC clocks
//                  and raises sticky timeout_err.
//     undefined -> no watchdog, WAIT lasts until adc_dv, timeout_err = 0.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   ch_en[1:0]    channel enable mask, sampled only on the frame tick
//   clr_err       clears overrun / timeout_err (a same-cycle set wins)
//   adc_busy      SPI master transaction in progress
//   adc_dv        one-cycle result strobe from the SPI master
//   adc_data[11:0] conversion result from the SPI master
//   adc_start     one-cycle conversion request
//   adc_odd       channel select of the request (0 = CH0, 1 = CH1)
//   adc_sgl       constant SGL (single-ended / differential)
//   ch0_data, ch1_data  last result per channel
//   ch_dv[1:0]    one-cycle per-channel new-result strobe
//   overrun       sticky: a frame ended with conversions still pending
//   timeout_err   sticky: a conversion was aborted by the watchdog
// ---------------------------------------------------------------------------

// Per-channel result register: loads on its strobe, holds otherwise.
module mcp3202_chan_reg #(
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] q,
   output logic          dv
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= '0;
         dv <= 1'b0;
      end else begin
         dv <= load;
         if (load) q <= din;
      end
   end
endmodule

module mcp3202_chan_sched #(
   parameter int FCLK        = 100_000_000,
   parameter int FSMPL       = 500,
   parameter bit SGL         = 1'b1,
   parameter int TIMEOUT_CYC = 40000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  ch_en,
   input  logic        clr_err,
   input  logic        adc_busy,
   input  logic        adc_dv,
   input  logic [11:0] adc_data,
   output logic        adc_start,
   output logic        adc_odd,
   output logic        adc_sgl,
   output logic [11:0] ch0_data,
   output logic [11:0] ch1_data,
   output logic [1:0]  ch_dv,
   output logic        overrun,
   output logic        timeout_err
);
   localparam int NUM_CH = 2;
   localparam int DW     = 12;
   localparam int DIV    = FCLK / FSMPL;
   localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;

   // Reject configurations that cannot produce a periodic tick or a watchdog.
   if (DIV < 2 || TIMEOUT_CYC < 1) begin : g_param_err
      $error("mcp3202_chan_sched: FCLK/FSMPL must be >= 2 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      tcnt;
   logic               tick;
   logic [NUM_CH-1:0]  pending, pending_nxt, done_mask, remain;
   logic               sel, sel_nxt;
   logic               dv_hit;
   logic               wd_abort;
   logic [NUM_CH-1:0][DW-1:0] ch_q;

   assign adc_sgl = SGL;
   assign adc_odd = sel;   // sel only changes on the IDLE->ISSUE step

   // ---------------- frame tick ----------------
   assign tick = (tcnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    tcnt <= '0;
      else if (tick) tcnt <= '0;
      else           tcnt <= tcnt + 1'b1;
   end

   // ---------------- watchdog ----------------
`ifdef MCP3202_SCHED_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] wd_cnt;
   logic          wd_hit;

   // Counts cycles spent in WAIT; zero on WAIT entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              wd_cnt <= '0;
      else if (state != WAIT)  wd_cnt <= '0;
      else                     wd_cnt <= wd_cnt + 1'b1;
   end

   assign wd_hit = (wd_cnt == WW'(TIMEOUT_CYC - 1));
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 1'b0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      adc_start = 1'b0;
      dv_hit    = 1'b0;
      wd_abort  = 1'b0;
      case (state)
         IDLE: begin
            if ((|pending) && !adc_busy) begin
               sel_nxt   = ~pending[0];   // lowest set bit: CH0 before CH1
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            adc_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (adc_dv) begin
               dv_hit    = 1'b1;
               state_nxt = IDLE;
            end
`ifdef MCP3202_SCHED_TIMEOUT_EN
            else if (wd_hit) begin
               wd_abort  = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- pending / error flags ----------------
   // A completed or aborted conversion retires its own pending bit only.
   assign done_mask   = (dv_hit || wd_abort) ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign remain      = pending & ~done_mask;
   assign pending_nxt = remain | (tick ? ch_en : 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                overrun <= 1'b0;
      else if (tick && |remain)  overrun <= 1'b1;
      else if (clr_err)          overrun <= 1'b0;
   end

`ifdef MCP3202_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        timeout_err <= 1'b0;
      else if (wd_abort) timeout_err <= 1'b1;
      else if (clr_err)  timeout_err <= 1'b0;
   end
`else
   assign timeout_err = 1'b0;
`endif

   // ---------------- result demux ----------------
   // Only the channel matching sel loads, so ch_dv is never both-high.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mcp3202_chan_reg #(.DW(DW)) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (dv_hit && (sel == c[0])),
         .din   (adc_data),
         .q     (ch_q[c]),
         .dv    (ch_dv[c])
      );
   end

   assign ch0_data = ch_q[0];
   assign ch1_data = ch_q[1];

endmodule

// File: tb/tb_mcp3202_chan_sched.sv
// Bench for mcp3202_chan_sched: FCLK=1000, FSMPL=10 (tick every 100 clk).
// All activity runs in one process: clk1() advances one clock, samples the
// DUT, scores result strobes against a queue filled at each adc_start, and
// steps a behavioural SPI master model.
module tb_mcp3202_chan_sched;
   localparam int TO_CYC = 50;
`ifdef MCP3202_SCHED_TIMEOUT_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  ch_en = 2'b00;
   logic        clr_err = 1'b0;
   logic        adc_busy;
   logic        adc_dv = 1'b0;
   logic [11:0] adc_data = 12'h000;
   logic        adc_start, adc_odd, adc_sgl;
   logic [11:0] ch0_data, ch1_data;
   logic [1:0]  ch_dv;
   logic        overrun, timeout_err;

   logic m_busy = 1'b0, force_busy = 1'b0;
   assign adc_busy = m_busy | force_busy;

   mcp3202_chan_sched #(
      .FCLK(1000), .FSMPL(10), .SGL(1'b1), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .clr_err(clr_err),
      .adc_busy(adc_busy), .adc_dv(adc_dv), .adc_data(adc_data),
      .adc_start(adc_start), .adc_odd(adc_odd), .adc_sgl(adc_sgl),
      .ch0_data(ch0_data), .ch1_data(ch1_data), .ch_dv(ch_dv),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {logic ch; logic [11:0] d;} sb_t;
   sb_t sb[$];

   int   nchk = 0, nbad = 0;
   int   cyc = 0;
   int   starts [2];
   int   dvs [2];
   int   first_start = -1;
   int   m_dly = 20;       // 0 = model never answers
   int   m_cnt = 0;
   logic m_active = 1'b0;
   logic m_odd = 1'b0;
   logic m_kill = 1'b0;
   logic prev_dv = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clk1();
      sb_t e;
      logic just;
      @(posedge clk); #1;
      cyc++;
      just = 1'b0;
      if (!rst_n) begin
         sb.delete();
         starts = '{0, 0};
         dvs = '{0, 0};
      end else begin
         if (ch_dv != 2'b00) begin
            dvs[ch_dv[1]]++;
            check("chdv_after_dv", int'(prev_dv), 1);
            if (sb.size() == 0) check("chdv_unexpected", int'(ch_dv), 0);
            else begin
               e = sb.pop_front();
               check("chdv_ch", int'(ch_dv), e.ch ? 2 : 1);
               check("chdv_data", int'(e.ch ? ch1_data : ch0_data), int'(e.d));
            end
         end
         if (adc_start) begin
            starts[adc_odd]++;
            if (first_start < 0) first_start = cyc;
            e.ch = adc_odd;
            e.d  = adc_odd ? 12'h123 : 12'hABC;
            sb.push_back(e);
            m_active = 1'b1;
            m_busy   = 1'b1;
            m_cnt    = m_dly;
            m_odd    = adc_odd;
            just     = 1'b1;
         end
      end
      // SPI master model (not reset by the scheduler's reset)
      adc_dv = 1'b0;
      if (m_kill) begin
         m_active = 1'b0;
         m_busy   = 1'b0;
      end else if (m_active && !just && m_dly > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            adc_dv   = 1'b1;
            adc_data = m_odd ? 12'h123 : 12'hABC;
            m_active = 1'b0;
            m_busy   = 1'b0;
         end
      end
      prev_dv = adc_dv;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) clk1();
   endtask

   // Asserts reset mid-cycle, checks reset values, holds 3 clk, releases.
   task automatic do_reset();
      clk1();
      rst_n = 1'b0;
      #1;
      check("rst_vals",
            int'({adc_start, adc_odd, adc_sgl, ch0_data, ch1_data, ch_dv, overrun, timeout_err}),
            int'({3'b001, 28'h0}));
      repeat (3) clk1();
      rst_n = 1'b1;
      cyc = 0;
      first_start = -1;
   endtask

   typedef struct {
      logic [1:0]  en;
      int          s0, s1;
      logic [11:0] d0, d1;
   } vec_t;
   vec_t tv [4];

   initial begin
      tv[0] = '{2'b11, 3, 3, 12'hABC, 12'h123};
      tv[1] = '{2'b10, 0, 3, 12'h000, 12'h123};
      tv[2] = '{2'b01, 3, 0, 12'hABC, 12'h000};
      tv[3] = '{2'b00, 0, 0, 12'h000, 12'h000};
      starts = '{0, 0};
      dvs = '{0, 0};

      // Table: three frames (ticks at cyc 99/199/299) per enable mask.
      m_dly = 20;
      for (int i = 0; i < 4; i++) begin
         ch_en = tv[i].en;
         do_reset();
         run_to(360);
         check($sformatf("v%0d_starts0", i), starts[0], tv[i].s0);
         check($sformatf("v%0d_starts1", i), starts[1], tv[i].s1);
         check($sformatf("v%0d_dv0", i), dvs[0], tv[i].s0);
         check($sformatf("v%0d_dv1", i), dvs[1], tv[i].s1);
         check($sformatf("v%0d_ch0", i), int'(ch0_data), int'(tv[i].d0));
         check($sformatf("v%0d_ch1", i), int'(ch1_data), int'(tv[i].d1));
         check($sformatf("v%0d_ovr", i), int'(overrun), 0);
         check($sformatf("v%0d_sb_empty", i), sb.size(), 0);
      end

      // Overrun: 120 clk conversion outlives the frame.
      m_dly = 120;
      ch_en = 2'b01;
      do_reset();
      run_to(150); check("ovr_before", int'(overrun), 0);
      run_to(205); check("ovr_set", int'(overrun), 1);
      check("ovr_dv0", dvs[0], 0);
      run_to(250); clr_err = 1'b1; clk1(); clr_err = 1'b0;
      run_to(260); check("ovr_cleared", int'(overrun), 0);
      run_to(350); check("ovr_stays_clr", int'(overrun), 0);
      run_to(405); check("ovr_reset_again", int'(overrun), 1);
      check("ovr_dv0_done", dvs[0], 1);

      // Watchdog: model never answers.
      m_dly = 0;
      ch_en = 2'b01;
      do_reset();
      run_to(140); check("to_early", int'(timeout_err), 0);
      run_to(160); check("to_fired", int'(timeout_err), int'(WD));
      m_kill = 1'b1; clk1(); m_kill = 1'b0;
      run_to(215);
      check("to_restarts", starts[0], WD ? 2 : 1);
      check("to_no_chdv", dvs[0] + dvs[1], 0);
      clr_err = 1'b1; clk1(); clr_err = 1'b0;
      run_to(220); check("to_clr", int'(timeout_err), 0);
      run_to(260); check("to_fired2", int'(timeout_err), int'(WD));
      m_kill = 1'b1; clk1(); m_kill = 1'b0;

      // Reset while in WAIT: stale dv must not produce ch_dv.
      m_dly = 20;
      ch_en = 2'b11;
      do_reset();
      run_to(210);
      check("pre_rst_ch0", int'(ch0_data), 12'hABC);
      do_reset();
      while (first_start < 0 && cyc < 300) clk1();
      check("rst_first_start", first_start, 101);
      check("rst_stale_dv", dvs[0] + dvs[1], 0);
      check("rst_first_odd", int'(adc_odd), 0);

      // Busy held across a tick.
      force_busy = 1'b1;
      do_reset();
      run_to(150);
      check("busy_no_start", starts[0] + starts[1], 0);
      force_busy = 1'b0;
      begin
         int rel;
         rel = cyc;
         while (first_start < 0 && cyc < 170) clk1();
         check("busy_rel_lat", int'(first_start - rel >= 1 && first_start - rel <= 2), 1);
         check("busy_rel_odd", int'(adc_odd), 0);
      end
      run_to(200);
      check("busy_both_done", dvs[0] * 10 + dvs[1], 11);

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end
endmodule
